seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed driver for a multi-digit common-anode 7-segment display. It holds NUM_DIGITS 4-bit values and scans them onto one shared segment bus, one digit per scan slot. Features: per-digit enable, decimal points, leading-zero suppression, hex/decimal mode, anti-ghost blanking and tear-free frame-synchronous update. Sits between the board's display-data registers and the physical seg/anode pins.

---
 rtl/seg7_scan_driver.sv | 150 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a common-anode multi-digit 7-segment display.
// Scans frame-synchronously committed digit values onto a shared segment bus.
module seg7_scan_driver #(
   parameter int NUM_DIGITS     = 8,
   parameter int SCAN_DIV       = 1000,
   parameter int BLANK_CYCLES   = 2,
   parameter bit ACTIVE_LOW_SEG = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    lz_suppress,
   input  logic                    dec_mode,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

   localparam logic [6:0] SEG_DARK = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
   localparam logic       DP_DARK  = ACTIVE_LOW_SEG ? 1'b1 : 1'b0;
   localparam logic [6:0] SEG_DASH = 7'h3F;

   // One complete set of display content; pending and display copies share it.
   typedef struct packed {
      logic [4*NUM_DIGITS-1:0] vals;
      logic [NUM_DIGITS-1:0]   dps;
      logic [NUM_DIGITS-1:0]   ens;
   } frame_t;

   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic          tick;
   logic          commit;

   frame_t        incoming;
   frame_t        pend;
   frame_t        disp;

   logic [3:0]            cur_val;
   logic                  cur_dp;
   logic [NUM_DIGITS-1:0] supp;
   logic                  zero_above;
   logic                  visible;
   logic                  lit;
   logic [6:0]            pattern;

   // Active-low segment patterns for the 16 hex values.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      case (v)
         4'h0:    return 7'h40;
         4'h1:    return 7'h79;
         4'h2:    return 7'h24;
         4'h3:    return 7'h30;
         4'h4:    return 7'h19;
         4'h5:    return 7'h12;
         4'h6:    return 7'h02;
         4'h7:    return 7'h78;
         4'h8:    return 7'h00;
         4'h9:    return 7'h10;
         4'hA:    return 7'h08;
         4'hB:    return 7'h03;
         4'hC:    return 7'h46;
         4'hD:    return 7'h21;
         4'hE:    return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

   assign incoming = '{vals: data, dps: dp_in, ens: digit_en};
   assign tick     = (cnt == CNT_LAST);
   assign commit   = tick && (idx == IDX_LAST);

   // NOTE: every clocked block uses non-blocking assignments so all flops
   // sample the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (tick) begin
         cnt <= '0;
         idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // Display content only changes at the frame boundary; a load landing on
   // that very cycle goes straight through so it is not lost for a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= '0;
         disp <= '0;
      end else begin
         if (load) begin
            pend <= incoming;
         end
         if (commit) begin
            disp <= load ? incoming : pend;
         end
      end
   end

   assign cur_val = disp.vals[4*idx +: 4];
   assign cur_dp  = disp.dps[idx];

   // NOTE: combinational blocks give every target a default first, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      supp       = '0;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         supp[i] = lz_suppress && (i != 0) && zero_above
                   && (disp.vals[4*i +: 4] == 4'h0);
         // Only an enabled non-zero digit ends the run of leading zeros.
         if (disp.ens[i] && (disp.vals[4*i +: 4] != 4'h0)) begin
            zero_above = 1'b0;
         end
      end
   end

   assign visible = disp.ens[idx] && !supp[idx];
   assign lit     = visible && (cnt >= CNT_BLANK);
   assign pattern = (dec_mode && (cur_val >= 4'd10)) ? SEG_DASH : hex_to_seg(cur_val);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an         <= '1;
         seg        <= SEG_DARK;
         dp         <= DP_DARK;
         frame_done <= 1'b0;
      end else begin
         an         <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
         seg        <= ACTIVE_LOW_SEG ? pattern : ~pattern;
         dp         <= ACTIVE_LOW_SEG ? ~cur_dp : cur_dp;
         frame_done <= commit;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed and random loads checked cycle by cycle
// against a frame-level model, on both segment polarities.
module tb_seg7_scan_driver;

   localparam int N     = 4;
   localparam int SD    = 4;
   localparam int BL    = 1;
   localparam int FRAME = N * SD;

   localparam logic [6:0] HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   logic           clk = 1'b0;
   logic           rst_n;
   logic           load;
   logic [4*N-1:0] data;
   logic [N-1:0]   dp_in;
   logic [N-1:0]   digit_en;
   logic           lz_suppress;
   logic           dec_mode;

   logic [6:0]     seg,   seg_i;
   logic           dp,    dp_i;
   logic [N-1:0]   an,    an_i;
   logic           frame_done, frame_done_i;

   int checks = 0;
   int errors = 0;
   int fd_count = 0;

   // Model state: cycles since reset release plus the pending/shown content.
   int             k;
   logic [4*N-1:0] pend_data, disp_data;
   logic [N-1:0]   pend_dp,   disp_dp;
   logic [N-1:0]   pend_en,   disp_en;

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BL), .ACTIVE_LOW_SEG(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .data(data), .dp_in(dp_in),
      .digit_en(digit_en), .lz_suppress(lz_suppress), .dec_mode(dec_mode),
      .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
   );

   seg7_scan_driver #(
      .NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BL), .ACTIVE_LOW_SEG(1'b0)
   ) dut_inv (
      .clk(clk), .rst_n(rst_n), .load(load), .data(data), .dp_in(dp_in),
      .digit_en(digit_en), .lz_suppress(lz_suppress), .dec_mode(dec_mode),
      .seg(seg_i), .dp(dp_i), .an(an_i), .frame_done(frame_done_i)
   );

   function automatic logic [3:0] digit_of(input logic [4*N-1:0] v, input int i);
      return v[4*i +: 4];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s (k=%0d): observed %0h expected %0h", tag, k, obs, exp);
      end
   endtask

   task automatic model_clear();
      k         = 0;
      pend_data = '0; disp_data = '0;
      pend_dp   = '0; disp_dp   = '0;
      pend_en   = '0; disp_en   = '0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_an"},       an,           {N{1'b1}});
      chk({tag, "_seg"},      seg,          7'h7F);
      chk({tag, "_dp"},       dp,           1'b1);
      chk({tag, "_fd"},       frame_done,   1'b0);
      chk({tag, "_an_inv"},   an_i,         {N{1'b1}});
      chk({tag, "_seg_inv"},  seg_i,        7'h00);
      chk({tag, "_dp_inv"},   dp_i,         1'b0);
      chk({tag, "_fd_inv"},   frame_done_i, 1'b0);
   endtask

   // One clock: predict the outputs from the slot the model is in, advance
   // the model on the edge, then compare just after the edge.
   task automatic cycle(input bit ld);
      int         pos, d;
      bit         suppressed, vis, e_fd;
      logic [3:0] v;
      logic [N-1:0] e_an;
      logic [6:0] e_seg, e_seg_n;
      logic       e_dp, e_dp_n;

      load = ld;
      pos  = k % SD;
      d    = (k / SD) % N;
      v    = digit_of(disp_data, d);

      suppressed = 1'b0;
      if (lz_suppress && d > 0 && v == 4'h0) begin
         suppressed = 1'b1;
         for (int j = d + 1; j < N; j++)
            if (disp_en[j] && digit_of(disp_data, j) != 4'h0) suppressed = 1'b0;
      end
      vis  = disp_en[d] && !suppressed;
      e_an = '1;
      if (vis && pos >= BL) e_an[d] = 1'b0;
      e_seg   = (dec_mode && v >= 4'd10) ? 7'h3F : HEX_SEG[v];
      e_dp    = ~disp_dp[d];
      e_seg_n = ~e_seg;
      e_dp_n  = ~e_dp;
      e_fd    = ((k + 1) % FRAME) == 0;

      @(posedge clk);
      if (e_fd) begin
         disp_data = ld ? data     : pend_data;
         disp_dp   = ld ? dp_in    : pend_dp;
         disp_en   = ld ? digit_en : pend_en;
      end
      if (ld) begin
         pend_data = data;
         pend_dp   = dp_in;
         pend_en   = digit_en;
      end
      k++;
      #1;
      chk("an",         an,           e_an);
      chk("seg",        seg,          e_seg);
      chk("dp",         dp,           e_dp);
      chk("frame_done", frame_done,   e_fd);
      chk("an_inv",     an_i,         e_an);
      chk("seg_inv",    seg_i,        e_seg_n);
      chk("dp_inv",     dp_i,         e_dp_n);
      chk("fd_inv",     frame_done_i, e_fd);
      if (frame_done === 1'b1) fd_count++;
      load = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; load = 1'b0; data = '0; dp_in = '0; digit_en = '0;
      lz_suppress = 1'b0; dec_mode = 1'b0;
      model_clear();

      // Reset state, then release away from the clock edge.
      @(posedge clk); #1;
      chk_reset("reset_init");
      rst_n = 1'b1;

      // Load mid-frame 0: nothing may show until the frame boundary.
      repeat (5) cycle(1'b0);
      data = 16'h1234; digit_en = 4'hF; dp_in = 4'h0;
      cycle(1'b1);
      while (k % FRAME != 0) cycle(1'b0);
      cycle(1'b0); cycle(1'b0);
      chk("digit0_seg_1234", seg, 7'h19);
      chk("digit0_an_1234",  an,  4'b1110);
      repeat (12) cycle(1'b0);
      chk("digit3_seg_1234", seg, 7'h79);
      chk("digit3_an_1234",  an,  4'b0111);

      // Load landing exactly on the commit cycle.
      data = 16'h5678;
      while ((k + 1) % FRAME != 0) cycle(1'b0);
      cycle(1'b1);
      fd_count = 0;
      repeat (2 * FRAME) cycle(1'b0);
      chk("frame_done_count_en_f", fd_count, 2);

      // Leading-zero suppression on and off.
      data = 16'h0050; lz_suppress = 1'b1;
      cycle(1'b1);
      repeat (2 * FRAME) cycle(1'b0);
      lz_suppress = 1'b0;
      repeat (FRAME) cycle(1'b0);

      // Hex versus dash rendering of 'b', decimal point on digit 2.
      data = 16'h3B2B; dp_in = 4'b0100;
      cycle(1'b1);
      repeat (2 * FRAME) cycle(1'b0);
      dec_mode = 1'b1;
      repeat (FRAME) cycle(1'b0);
      dec_mode = 1'b0;

      // Disabled digits still consume their slots.
      digit_en = 4'b0101; data = 16'h9876;
      cycle(1'b1);
      repeat (FRAME) cycle(1'b0);
      fd_count = 0;
      repeat (2 * FRAME) cycle(1'b0);
      chk("frame_done_count_en_5", fd_count, 2);

      // Reset mid-scan, then confirm the first commit waits for frame 0's end.
      repeat (7) cycle(1'b0);
      rst_n = 1'b0;
      #1;
      chk_reset("reset_mid");
      @(posedge clk); #1;
      chk_reset("reset_held");
      rst_n = 1'b1;
      model_clear();
      repeat (3) cycle(1'b0);
      data = 16'hA0C1; digit_en = 4'hF; dp_in = 4'b1001;
      cycle(1'b1);
      repeat (2 * FRAME) cycle(1'b0);

      // Random loads and mode changes.
      for (int n = 0; n < 400; n++) begin
         bit ld;
         ld = ($urandom_range(0, 7) == 0);
         if (ld) begin
            data = 16'($urandom);
            if ($urandom_range(0, 1) == 1) data = data >> (4 * $urandom_range(1, 3));
            dp_in    = 4'($urandom);
            digit_en = 4'($urandom);
         end
         if ($urandom_range(0, 15) == 0) lz_suppress = 1'($urandom);
         if ($urandom_range(0, 15) == 0) dec_mode    = 1'($urandom);
         cycle(ld);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
